// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit_if
//  Description : Bundles the instruction-memory req/ack bus, the decode-side
//                valid/ready issue bus and the branch feedback of the fetch
//                unit into one interface.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_unit_if;
    // Instruction memory side
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Decode / issue side
    logic [31:0] instr;
    logic [5:0]  instr_op;
    logic [5:0]  funct;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        zero;
    logic [31:0] issue_count;

    // Fetch unit view
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr,
        output instr_op,
        output funct,
        output pc_out,
        output instr_valid,
        input  instr_ready,
        input  branch,
        input  zero,
        output issue_count
    );

    // Memory / decode environment view
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr,
        input  instr_op,
        input  funct,
        input  pc_out,
        input  instr_valid,
        output instr_ready,
        output branch,
        output zero,
        input  issue_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Holds the PC, fetches instruction words over a req/ack bus,
//                issues them over valid/ready and computes the next PC from
//                the branch/zero feedback of the issued instruction.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  wire                  clk,
    input  wire                  rst_n,
    instr_fetch_unit_if.master   bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_ISSUE = 2'd2;

    // Low PC bits forced to zero so the fetch address is always word-aligned
    localparam logic [31:0] c_PC_RESET = {PC_RESET[31:2], 2'b00};

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_imem_req;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic [31:0] r_issue_count;

    logic        w_issue_fire;
    logic        w_taken;
    logic [31:0] w_branch_offset;
    logic [31:0] w_pc_inc;
    logic [31:0] w_pc_next;

    // Next-PC: sequential or PC-relative branch target, all modulo 2^32
    always_comb begin
        w_issue_fire    = (r_state == c_ISSUE) && r_instr_valid && bus.instr_ready;
        w_taken         = bus.branch & bus.zero;
        w_branch_offset = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
        w_pc_inc        = r_pc + 32'd4;
        w_pc_next       = w_taken ? (w_pc_inc + w_branch_offset) : w_pc_inc;
    end

    // Fetch/issue sequencer; reset wins over any ack or ready on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_pc          <= c_PC_RESET;
            r_imem_req    <= 1'b0;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_issue_count <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_state    <= c_FETCH;
                    r_imem_req <= 1'b1;
                end
                c_FETCH: begin
                    if (bus.imem_ack) begin
                        r_instr       <= bus.imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (w_issue_fire) begin
                        r_pc          <= w_pc_next;
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_issue_count <= r_issue_count + 32'd1;
                        r_state       <= c_FETCH;
                    end
                end
                default: begin
                    r_state       <= c_IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_op    = r_instr[31:26];
    assign bus.funct       = r_instr[5:0];
    assign bus.pc_out      = r_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.issue_count = r_issue_count;

endmodule
`default_nettype wire
